// File: rtl/snake_vga_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snake_vga_driver_pkg
//  Description : Shared timing defaults (640x480@60, 25.175 MHz pixel clock)
//                and the counter type used by the snake VGA driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package snake_vga_driver_pkg;

    // Horizontal timing in pixel clocks; line origin is the first sync clock.
    localparam int SNAKE_H_SYNC   = 96;
    localparam int SNAKE_H_BACK   = 48;
    localparam int SNAKE_H_DISP   = 640;
    localparam int SNAKE_H_TOTAL  = 800;

    // Vertical timing in lines; frame origin is the first sync line.
    localparam int SNAKE_V_SYNC   = 2;
    localparam int SNAKE_V_BACK   = 33;
    localparam int SNAKE_V_DISP   = 480;
    localparam int SNAKE_V_TOTAL  = 525;

    // Latency of the pixel source between coordinate request and data.
    localparam int SNAKE_DATA_LAT = 2;

    localparam int CNT_W = 11;
    typedef logic [CNT_W-1:0] cnt_t;

    // Inclusive unsigned window test on a counter value.
    function automatic logic in_window(input cnt_t val, input cnt_t lo, input cnt_t hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_vga_driver.sv
`default_nettype none
// ============================================================================
//  Module      : snake_vga_driver
//  Description : VGA timing generator and pixel pipeline. Free-running h/v
//                counters (origin at start of sync) drive registered sync,
//                display-enable and RGB outputs, and a combinational pixel
//                coordinate request issued DATA_LAT clocks ahead of display.
//  Ports       : clk, rst          - pixel clock, synchronous active-high reset
//                pixel_data[15:0]  - RGB565 returned DATA_LAT clocks after request
//                pixel_xpos/ypos   - requested column/row (0 outside request window)
//                vga_hs / vga_vs   - active-low syncs
//                vga_de / vga_rgb  - display enable and RGB565 to DAC
//                frame_start       - one-clock pulse per frame
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_vga_driver
    import snake_vga_driver_pkg::*;
#(
    parameter int H_SYNC   = SNAKE_H_SYNC,
    parameter int H_BACK   = SNAKE_H_BACK,
    parameter int H_DISP   = SNAKE_H_DISP,
    parameter int H_TOTAL  = SNAKE_H_TOTAL,
    parameter int V_SYNC   = SNAKE_V_SYNC,
    parameter int V_BACK   = SNAKE_V_BACK,
    parameter int V_DISP   = SNAKE_V_DISP,
    parameter int V_TOTAL  = SNAKE_V_TOTAL,
    parameter int DATA_LAT = SNAKE_DATA_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [15:0] vga_rgb,
    output logic        frame_start
);

    localparam cnt_t C_H_MAX    = cnt_t'(H_TOTAL - 1);
    localparam cnt_t C_V_MAX    = cnt_t'(V_TOTAL - 1);
    localparam cnt_t C_H_SYNC   = cnt_t'(H_SYNC);
    localparam cnt_t C_V_SYNC   = cnt_t'(V_SYNC);
    localparam cnt_t C_H_ACT_LO = cnt_t'(H_SYNC + H_BACK);
    localparam cnt_t C_H_ACT_HI = cnt_t'(H_SYNC + H_BACK + H_DISP - 1);
    localparam cnt_t C_V_ACT_LO = cnt_t'(V_SYNC + V_BACK);
    localparam cnt_t C_V_ACT_HI = cnt_t'(V_SYNC + V_BACK + V_DISP - 1);
    // Request window leads the active window so data lands just in time.
    localparam cnt_t C_H_REQ_LO = cnt_t'(H_SYNC + H_BACK - DATA_LAT);
    localparam cnt_t C_H_REQ_HI = cnt_t'(H_SYNC + H_BACK + H_DISP - 1 - DATA_LAT);

    cnt_t        h_cnt_q, h_cnt_d;
    cnt_t        v_cnt_q, v_cnt_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic [15:0] rgb_q, rgb_d;
    logic        fs_q, fs_d;

    logic        w_v_active;
    logic        w_active;
    logic        w_req;

    always_comb begin
        h_cnt_d = h_cnt_q + cnt_t'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == C_H_MAX) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == C_V_MAX) ? '0 : v_cnt_q + cnt_t'(1);
        end

        w_v_active = in_window(v_cnt_q, C_V_ACT_LO, C_V_ACT_HI);
        w_active   = w_v_active && in_window(h_cnt_q, C_H_ACT_LO, C_H_ACT_HI);
        w_req      = w_v_active && in_window(h_cnt_q, C_H_REQ_LO, C_H_REQ_HI);

        hs_d  = (h_cnt_q >= C_H_SYNC);
        vs_d  = (v_cnt_q >= C_V_SYNC);
        de_d  = w_active;
        rgb_d = w_active ? pixel_data : 16'h0000;
        fs_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Coordinates are combinational; reset masks them so a source never sees
    // a stale request while the counters are being cleared.
    always_comb begin
        pixel_xpos = '0;
        pixel_ypos = '0;
        if (w_req && !rst) begin
            pixel_xpos = h_cnt_q - C_H_REQ_LO;
            pixel_ypos = v_cnt_q - C_V_ACT_LO;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            de_q    <= 1'b0;
            rgb_q   <= 16'h0000;
            fs_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
            fs_q    <= fs_d;
        end
    end

    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_de      = de_q;
    assign vga_rgb     = rgb_q;
    assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_vga_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snake_vga_driver
//  Description : Bench for snake_vga_driver. A reduced-timing instance takes
//                random, patterned and constant pixel data from a 2-clock
//                memory model; a default-timing instance runs alongside on the
//                same reset. Expected outputs come from elapsed-clock
//                arithmetic on the timing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_vga_driver;

    typedef struct {
        int hs, hb, hd, ht, vs, vb, vd, vt, lat;
    } tm_t;

    localparam int S_HS = 4, S_HB = 3, S_HD = 10, S_HT = 20;
    localparam int S_VS = 2, S_VB = 2, S_VD = 5,  S_VT = 12;
    localparam int S_FRAME = S_HT * S_VT;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pd_s, pd_d;
    logic [10:0] s_x, s_y, d_x, d_y;
    logic        s_hs, s_vs, s_de, s_fs, d_hs, d_vs, d_de, d_fs;
    logic [15:0] s_rgb, d_rgb;

    always #5 clk = ~clk;

    snake_vga_driver #(
        .H_SYNC(S_HS), .H_BACK(S_HB), .H_DISP(S_HD), .H_TOTAL(S_HT),
        .V_SYNC(S_VS), .V_BACK(S_VB), .V_DISP(S_VD), .V_TOTAL(S_VT),
        .DATA_LAT(2)
    ) u_dut_small (
        .clk(clk), .rst(rst), .pixel_data(pd_s),
        .pixel_xpos(s_x), .pixel_ypos(s_y),
        .vga_hs(s_hs), .vga_vs(s_vs), .vga_de(s_de),
        .vga_rgb(s_rgb), .frame_start(s_fs)
    );

    snake_vga_driver u_dut_def (
        .clk(clk), .rst(rst), .pixel_data(pd_d),
        .pixel_xpos(d_x), .pixel_ypos(d_y),
        .vga_hs(d_hs), .vga_vs(d_vs), .vga_de(d_de),
        .vga_rgb(d_rgb), .frame_start(d_fs)
    );

    int          passed = 0;
    int          total  = 0;
    tm_t         tm_s, tm_d;
    int          t;
    bit          outs_rst;
    int          mode;
    logic [15:0] mem [32][32];
    logic [15:0] d1, d2;
    bit          meas;
    int          fs_cnt, fs_first, fs_second, vs_low, de_high;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic logic [15:0] pix(input int m, input int x, input int y);
        logic [10:0] xx;
        logic [4:0]  yy;
        xx = 11'(x);
        yy = 5'(y);
        if (m == 0) return mem[y][x];
        if (m == 1) return {yy, xx};
        return 16'hFFFF;
    endfunction

    // Expected outputs during cycle t (t=0: first cycle after the last reset edge).
    task automatic model(input tm_t tm, input int m,
                         output logic [10:0] ex, output logic [10:0] ey,
                         output logic ehs, output logic evs, output logic ede,
                         output logic efs, output logic [15:0] ergb);
        int h, v, hp, vp, ax0, ay0;
        ax0 = tm.hs + tm.hb;
        ay0 = tm.vs + tm.vb;
        h = t % tm.ht;
        v = (t / tm.ht) % tm.vt;
        ex = '0; ey = '0;
        if (!rst && v >= ay0 && v < ay0 + tm.vd &&
            h + tm.lat >= ax0 && h + tm.lat < ax0 + tm.hd) begin
            ex = 11'(h + tm.lat - ax0);
            ey = 11'(v - ay0);
        end
        if (outs_rst) begin
            ehs = 1'b1; evs = 1'b1; ede = 1'b0; efs = 1'b0; ergb = 16'h0000;
        end else begin
            hp = (t - 1) % tm.ht;
            vp = ((t - 1) / tm.ht) % tm.vt;
            ehs  = (hp >= tm.hs);
            evs  = (vp >= tm.vs);
            ede  = (hp >= ax0 && hp < ax0 + tm.hd && vp >= ay0 && vp < ay0 + tm.vd);
            efs  = (hp == 0 && vp == 0);
            ergb = ede ? pix(m, hp - ax0, vp - ay0) : 16'h0000;
        end
    endtask

    // One clock: advance the model, check both instances, then drive inputs
    // for the next edge (memory model answers requests two clocks later).
    task automatic cycle(input bit next_rst);
        logic [10:0] ex, ey;
        logic        ehs, evs, ede, efs;
        logic [15:0] ergb, f;
        @(posedge clk);
        #1;
        if (rst) begin t = 0; outs_rst = 1'b1; end
        else begin t++; outs_rst = 1'b0; end

        model(tm_s, mode, ex, ey, ehs, evs, ede, efs, ergb);
        chk("s_xpos", 32'(s_x), 32'(ex));
        chk("s_ypos", 32'(s_y), 32'(ey));
        chk("s_hs", 32'(s_hs), 32'(ehs));
        chk("s_vs", 32'(s_vs), 32'(evs));
        chk("s_de", 32'(s_de), 32'(ede));
        chk("s_fs", 32'(s_fs), 32'(efs));
        chk("s_rgb", 32'(s_rgb), 32'(ergb));

        model(tm_d, 2, ex, ey, ehs, evs, ede, efs, ergb);
        chk("d_xpos", 32'(d_x), 32'(ex));
        chk("d_ypos", 32'(d_y), 32'(ey));
        chk("d_hs", 32'(d_hs), 32'(ehs));
        chk("d_vs", 32'(d_vs), 32'(evs));
        chk("d_de", 32'(d_de), 32'(ede));
        chk("d_fs", 32'(d_fs), 32'(efs));
        chk("d_rgb", 32'(d_rgb), 32'(ergb));

        if (meas) begin
            if (s_fs === 1'b1 && t >= 1 && t <= 2 * S_FRAME) begin
                fs_cnt++;
                if (fs_cnt == 1) fs_first = t;
                if (fs_cnt == 2) fs_second = t;
            end
            if (t >= 1 && t <= S_FRAME) begin
                if (s_vs === 1'b0) vs_low++;
                if (s_de === 1'b1) de_high++;
            end
        end

        if (mode == 0)      f = mem[s_y[4:0]][s_x[4:0]];
        else if (mode == 1) f = {s_y[4:0], s_x};
        else                f = 16'hFFFF;
        pd_s = (mode == 2) ? 16'hFFFF : d2;
        d2 = d1;
        d1 = f;
        rst = next_rst;
    endtask

    initial begin
        int tgt, guard;
        tm_s = '{S_HS, S_HB, S_HD, S_HT, S_VS, S_VB, S_VD, S_VT, 2};
        tm_d = '{96, 48, 640, 800, 2, 33, 480, 525, 2};
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++)
                mem[y][x] = 16'($urandom);
        rst = 1'b1; pd_s = 16'h0000; pd_d = 16'hFFFF;
        d1 = 16'h0000; d2 = 16'h0000;
        mode = 0; t = 0; outs_rst = 1'b1; meas = 1'b0;
        fs_cnt = 0; fs_first = -1; fs_second = -1; vs_low = 0; de_high = 0;

        // Reset for three edges, then random memory contents for four frames
        // (also covers the first 800-clock vsync line of the default instance).
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b0);
        while (t < 4 * S_FRAME) cycle(1'b0);

        // Address pattern frames, then constant white frame.
        mode = 1;
        while (t < 6 * S_FRAME) cycle(1'b0);
        mode = 2;
        while (t < 7 * S_FRAME) cycle(1'b0);

        // Abort a frame with a 3-clock reset somewhere in the active region.
        mode = 0;
        tgt = $urandom_range(6 * S_HT + 8, 6 * S_HT + 14);
        guard = 0;
        while ((t % S_FRAME) != tgt && guard < 2 * S_FRAME) begin
            cycle(1'b0);
            guard++;
        end
        chk("reset_point_reached", 32'(t % S_FRAME), 32'(tgt));
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b0);
        meas = 1'b1;
        while (t < 2 * S_FRAME) cycle(1'b0);
        cycle(1'b0);

        chk("fs_count_two_frames", 32'(fs_cnt), 32'd2);
        chk("fs_first_after_release", 32'(fs_first), 32'd1);
        chk("fs_spacing", 32'(fs_second - fs_first), 32'(S_FRAME));
        chk("vs_low_clocks", 32'(vs_low), 32'(S_VS * S_HT));
        chk("de_high_clocks", 32'(de_high), 32'(S_VD * S_HD));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
